// File: rtl/word_unpacker_pkg.sv
// Shared message-parsing constants and types for the FIFO word unpacker.
package word_unpacker_pkg;

  localparam int unsigned UNP_WORD_W         = 64;
  localparam int unsigned UNP_LOG_W          = 3;
  localparam int unsigned UNP_BYTES_PER_WORD = 1 << UNP_LOG_W;
  localparam int unsigned UNP_BYTE_W         = 8;
  localparam int unsigned UNP_COUNT_W        = 16;

  typedef enum logic {
    UNP_IDLE = 1'b0,
    UNP_EMIT = 1'b1
  } unp_state_e;

endpackage

// File: rtl/word_unpacker.sv
// Pops words from a first-word-fall-through FIFO and streams them out MSB byte first
// with a valid/ack handshake; back-to-back words are emitted without a bubble.
module word_unpacker
  import word_unpacker_pkg::*;
#(
  parameter int unsigned WordWidth = UNP_WORD_W,
  parameter int unsigned LogWidth  = UNP_LOG_W
) (
  input  logic                   block1_clk,
  input  logic                   block1_reset,
  input  logic                   unp_empty,
  input  logic [WordWidth-1:0]   unp_r_data,
  output logic                   unp_rd,
  output logic                   unp_ByteValid,
  output logic [UNP_BYTE_W-1:0]  unp_Byte,
  output logic                   unp_ByteLast,
  input  logic                   unp_ByteAck,
  output logic [UNP_COUNT_W-1:0] unp_WordCount
);

  localparam int unsigned IdxW         = (LogWidth > 0) ? LogWidth : 1;
  localparam int unsigned BytesPerWord = 1 << LogWidth;
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(BytesPerWord - 1);

  unp_state_e             state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [WordWidth-1:0]   shreg_q, shreg_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic [UNP_COUNT_W-1:0] count_q, count_d;

  // State and datapath registers.
  always_ff @(posedge block1_clk or posedge block1_reset) begin
    if (block1_reset) begin
      state_q <= UNP_IDLE;
      idx_q   <= '0;
      shreg_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  // Next-state, pop strobe and datapath updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    count_d = count_q;
    unp_rd  = 1'b0;

    case (state_q)
      UNP_IDLE: begin
        if (!unp_empty) begin
          unp_rd  = 1'b1;
          shreg_d = unp_r_data;
          idx_d   = '0;
          state_d = UNP_EMIT;
        end
      end
      UNP_EMIT: begin
        if (unp_ByteAck) begin
          if (idx_q != LastIdx) begin
            shreg_d = shreg_q << UNP_BYTE_W;
            idx_d   = idx_q + IdxW'(1);
          end else if (!unp_empty) begin
            // Chain straight into the next word so valid never drops.
            unp_rd  = 1'b1;
            shreg_d = unp_r_data;
            idx_d   = '0;
          end else begin
            shreg_d = shreg_q << UNP_BYTE_W;
            idx_d   = '0;
            state_d = UNP_IDLE;
          end
        end
      end
      default: state_d = UNP_IDLE;
    endcase

    // Held word is abandoned on reset, so no pop may escape while it is high.
    if (block1_reset) begin
      unp_rd = 1'b0;
    end

    if (unp_rd) begin
      count_d = count_q + UNP_COUNT_W'(1);
    end

    valid_d = (state_d == UNP_EMIT);
    last_d  = (state_d == UNP_EMIT) && (idx_d == LastIdx);
  end

  assign unp_ByteValid = valid_q;
  assign unp_ByteLast  = last_q;
  assign unp_Byte      = shreg_q[WordWidth-1 -: UNP_BYTE_W];
  assign unp_WordCount = count_q;

endmodule

// File: tb/tb_word_unpacker.sv
// Self-checking bench for word_unpacker: queue-based byte model plus directed and random traffic,
// and a narrow-word instance that drives the word counter through its wrap.
module tb_word_unpacker;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main 64-bit instance
  logic        rst;
  logic        empty;
  logic        ack;
  logic [63:0] rdata;
  logic        rd;
  logic        bv;
  logic [7:0]  ubyte;
  logic        last;
  logic [15:0] wc;

  word_unpacker #(.WordWidth(64), .LogWidth(3)) u_dut (
    .block1_clk    (clk),
    .block1_reset  (rst),
    .unp_empty     (empty),
    .unp_r_data    (rdata),
    .unp_rd        (rd),
    .unp_ByteValid (bv),
    .unp_Byte      (ubyte),
    .unp_ByteLast  (last),
    .unp_ByteAck   (ack),
    .unp_WordCount (wc)
  );

  // Single-byte-word instance: one pop per cycle, used to reach the counter wrap quickly
  logic        rst2;
  logic        empty2;
  logic        ack2;
  logic [7:0]  rdata2;
  logic        rd2;
  logic        bv2;
  logic [7:0]  byte2;
  logic        last2;
  logic [15:0] wc2;

  word_unpacker #(.WordWidth(8), .LogWidth(0)) u_wrap (
    .block1_clk    (clk),
    .block1_reset  (rst2),
    .unp_empty     (empty2),
    .unp_r_data    (rdata2),
    .unp_rd        (rd2),
    .unp_ByteValid (bv2),
    .unp_Byte      (byte2),
    .unp_ByteLast  (last2),
    .unp_ByteAck   (ack2),
    .unp_WordCount (wc2)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Behavioural model: FIFO contents, bytes still owed from the held word, pop count
  logic [63:0] fifo[$];
  logic [7:0]  m_bytes[$];
  logic [15:0] m_count;

  // Observation logs for the hand-computed scenario checks
  logic [7:0]  dut_log[$];
  int unsigned last_cnt;
  logic [7:0]  last_byte;
  int unsigned rd_pulses;
  int unsigned valid_run;
  int unsigned max_run;
  int unsigned valid_cycles;
  int unsigned hold04;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_logs();
    dut_log.delete();
    last_cnt     = 0;
    last_byte    = 8'h00;
    rd_pulses    = 0;
    valid_run    = 0;
    max_run      = 0;
    valid_cycles = 0;
    hold04       = 0;
  endtask

  // One clock cycle: compare outputs against the model, drive inputs, check the pop, advance the model.
  task automatic tick(input logic a, input logic r);
    logic exp_valid;
    logic exp_rd;
    logic xfer;
    logic [63:0] w;
    @(negedge clk);
    exp_valid = (m_bytes.size() != 0);
    check("valid", 64'(bv), 64'(exp_valid));
    check("last", 64'(last), 64'(m_bytes.size() == 1));
    check("count", 64'(wc), 64'(m_count));
    if (exp_valid) check("byte", 64'(ubyte), 64'(m_bytes[0]));
    if (bv) begin
      valid_run++;
      valid_cycles++;
      if (valid_run > max_run) max_run = valid_run;
      if (ubyte == 8'h04) hold04++;
    end else begin
      valid_run = 0;
    end

    rst = r;
    if (r) begin
      m_bytes.delete();
      m_count = 16'h0000;
    end
    ack   = a;
    empty = (fifo.size() == 0);
    rdata = empty ? {$urandom, $urandom} : fifo[0];
    #1;
    if (r) begin
      check("rst_valid", 64'(bv), 64'd0);
      check("rst_byte", 64'(ubyte), 64'd0);
      check("rst_last", 64'(last), 64'd0);
      check("rst_count", 64'(wc), 64'd0);
    end
    exp_rd = !r && !empty && (m_bytes.size() == 0 || (m_bytes.size() == 1 && a));
    check("rd", 64'(rd), 64'(exp_rd));
    if (rd) rd_pulses++;
    xfer = (m_bytes.size() != 0) && a && !r;
    if (bv && a) begin
      dut_log.push_back(ubyte);
      if (last) begin
        last_cnt++;
        last_byte = ubyte;
      end
    end

    @(posedge clk);
    if (!r) begin
      if (xfer) void'(m_bytes.pop_front());
      if (exp_rd) begin
        w = fifo.pop_front();
        for (int i = 7; i >= 0; i--) m_bytes.push_back(w[i*8 +: 8]);
        m_count = m_count + 16'd1;
      end
    end
  endtask

  task automatic run_main();
    rst   = 1'b1;
    empty = 1'b1;
    ack   = 1'b0;
    rdata = '0;
    m_count = 16'h0000;
    clear_logs();
    repeat (3) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);

    // Single word, ack always high
    clear_logs();
    fifo.push_back(64'h0102030405060708);
    repeat (12) tick(1'b1, 1'b0);
    check("s1_nbytes", 64'(dut_log.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      if (i < dut_log.size()) check("s1_byte", 64'(dut_log[i]), 64'(i + 1));
    check("s1_lastcnt", 64'(last_cnt), 64'd1);
    check("s1_lastbyte", 64'(last_byte), 64'h08);
    check("s1_rdpulses", 64'(rd_pulses), 64'd1);
    check("s1_run", 64'(max_run), 64'd8);
    check("s1_count", 64'(wc), 64'd1);

    // Two words back to back: no bubble between them
    clear_logs();
    fifo.push_back(64'h1112131415161718);
    fifo.push_back(64'h2122232425262728);
    repeat (20) tick(1'b1, 1'b0);
    check("s2_nbytes", 64'(dut_log.size()), 64'd16);
    if (dut_log.size() == 16) begin
      check("s2_first", 64'(dut_log[0]), 64'h11);
      check("s2_ninth", 64'(dut_log[8]), 64'h21);
      check("s2_final", 64'(dut_log[15]), 64'h28);
    end
    check("s2_run", 64'(max_run), 64'd16);
    check("s2_rdpulses", 64'(rd_pulses), 64'd2);
    check("s2_count", 64'(wc), 64'd3);

    // Ack withheld for three cycles on byte 04
    clear_logs();
    fifo.push_back(64'h0102030405060708);
    tick(1'b1, 1'b0);
    repeat (3) tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    repeat (8) tick(1'b1, 1'b0);
    check("s3_nbytes", 64'(dut_log.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      if (i < dut_log.size()) check("s3_byte", 64'(dut_log[i]), 64'(i + 1));
    check("s3_hold04", 64'(hold04), 64'd4);
    check("s3_count", 64'(wc), 64'd4);

    // Reset in the middle of a word; the next FIFO word starts from its first byte
    clear_logs();
    fifo.push_back(64'hAABBCCDDEEFF0011);
    fifo.push_back(64'h1122334455667788);
    repeat (4) tick(1'b1, 1'b0);
    check("s4_pre_n", 64'(dut_log.size()), 64'd3);
    if (dut_log.size() == 3) check("s4_pre_3", 64'(dut_log[2]), 64'hCC);
    clear_logs();
    tick(1'b1, 1'b1);
    repeat (12) tick(1'b1, 1'b0);
    check("s4_nbytes", 64'(dut_log.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      if (i < dut_log.size()) check("s4_byte", 64'(dut_log[i]), 64'(8'h11 * (i + 1)));
    check("s4_rdpulses", 64'(rd_pulses), 64'd1);
    check("s4_count", 64'(wc), 64'd1);

    // FIFO empty with ack toggling: nothing may happen
    clear_logs();
    for (int i = 0; i < 20; i++) tick(1'(i % 2), 1'b0);
    check("s5_rdpulses", 64'(rd_pulses), 64'd0);
    check("s5_valid", 64'(valid_cycles), 64'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if (fifo.size() < 4 && $urandom_range(0, 3) == 0) fifo.push_back({$urandom, $urandom});
      tick(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 199) == 0));
    end
    fifo.delete();
    repeat (20) tick(1'b1, 1'b0);
  endtask

  task automatic run_wrap();
    int unsigned pops;
    logic [7:0]  prev;
    pops   = 0;
    prev   = 8'h00;
    rst2   = 1'b1;
    empty2 = 1'b0;
    ack2   = 1'b1;
    rdata2 = 8'h00;
    repeat (3) @(negedge clk);
    check("w_rst_count", 64'(wc2), 64'd0);
    check("w_rst_rd", 64'(rd2), 64'd0);
    for (int c = 0; c < 65540; c++) begin
      @(negedge clk);
      if (c == 0) rst2 = 1'b0;
      if (pops == 65535) check("wrap_ffff", 64'(wc2), 64'hFFFF);
      if (pops == 65536) check("wrap_zero", 64'(wc2), 64'h0000);
      if (c % 4096 == 1) begin
        check("wrap_count", 64'(wc2), 64'(16'(pops)));
        check("wrap_valid", 64'(bv2), 64'd1);
        check("wrap_last", 64'(last2), 64'd1);
        check("wrap_byte", 64'(byte2), 64'(prev));
      end
      rdata2 = 8'($urandom);
      prev   = rdata2;
      #1;
      if (rd2) pops++;
    end
    check("wrap_reached", 64'(pops > 32'd65536), 64'd1);
  endtask

  initial begin
    rst2   = 1'b1;
    empty2 = 1'b1;
    ack2   = 1'b0;
    rdata2 = 8'h00;
    fork
      run_main();
      run_wrap();
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
